// File: rtl/wrom_pkg.sv
// Shared types and helpers for the banked weight ROM streamer: lane word type,
// FSM state encoding, bank-count derivation and the fixed weight image.
package wrom_pkg;

  localparam int WROM_LANE_MAX = 64;

  typedef logic [WROM_LANE_MAX-1:0] wrom_lane_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wrom_state_t;

  function automatic int wrom_banks(input int depth, input int bank_addr);
    return (depth + (1 << bank_addr) - 1) >> bank_addr;
  endfunction

  // Weight image: each lane is a pure function of its global word address and
  // lane index, so every bank can be generated without external init files.
  function automatic wrom_lane_t wrom_word(input int unsigned addr, input int unsigned lane);
    int unsigned h;
    h = (addr * 32'h9E37_79B1) ^ (lane * 32'h85EB_CA77) ^ 32'h5A5A_1234;
    h = h ^ (h >> 15);
    return {32'h0, h};
  endfunction

endpackage

// File: rtl/weight_rom_bank.sv
// One synchronous-read ROM bank covering global words BANK_ID*2**BANK_ADDR onward.
// The output register only loads on rd_en_i; words at or beyond DEPTH read as zero.
module weight_rom_bank
  import wrom_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM       = 256,
  parameter int BANK_ADDR = 9,
  parameter int DEPTH     = 576,
  parameter int BANK_ID   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_en_i,
  input  logic [BANK_ADDR-1:0]   rd_addr_i,
  output logic [NUM*WIDTH-1:0]   rd_data_o
);

  localparam int unsigned BANK_BASE = int'(BANK_ID) << BANK_ADDR;

  int unsigned          gaddr;
  wrom_lane_t           lane_word;
  logic [WIDTH-1:0]     lane_fold;
  logic [NUM*WIDTH-1:0] word_d;
  logic [NUM*WIDTH-1:0] data_q;

  // The image is wider than a lane; XOR-fold it down so every bit contributes.
  always_comb begin
    gaddr     = BANK_BASE + 32'(rd_addr_i);
    word_d    = '0;
    lane_word = '0;
    lane_fold = '0;
    if (gaddr < DEPTH) begin
      for (int l = 0; l < NUM; l++) begin
        lane_word = wrom_word(gaddr, l);
        lane_fold = '0;
        for (int b = 0; b < WROM_LANE_MAX; b++) begin
          lane_fold[b % WIDTH] = lane_fold[b % WIDTH] ^ lane_word[b];
        end
        word_d[l*WIDTH +: WIDTH] = lane_fold;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (rd_en_i) begin
      data_q <= word_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/weight_rom_streamer.sv
// Streams a block of NUM-lane weight words from a banked ROM, one word per cycle,
// behind a valid/ready output with one cycle of read latency. Optional macro WROM_WRAP_EN.
module weight_rom_streamer
  import wrom_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM       = 256,
  parameter int ADDR      = 10,
  parameter int DEPTH     = 576,
  parameter int BANK_ADDR = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR-1:0]   base_addr,
  input  logic [ADDR:0]     count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  rom_out [0:NUM-1],
  output logic [ADDR-1:0]   out_addr,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int              BANKS     = wrom_banks(DEPTH, BANK_ADDR);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [ADDR+1:0] DEPTH_X   = (ADDR+2)'(DEPTH);

  wrom_state_t          state_q;
  logic [ADDR-1:0]      rd_addr_q;
  logic [ADDR:0]        remain_q;
  logic [ADDR-1:0]      out_addr_q;
  logic [ADDR-1:0]      bank_sel_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 out_valid_q;

  logic                 rd_en;
  logic [ADDR-1:0]      rd_bank;
  logic [ADDR-1:0]      rd_addr_d;
  logic [ADDR+1:0]      end_addr;
  logic                 range_bad;

  logic [NUM*WIDTH-1:0] bank_data [BANKS];

  always_comb begin
    rd_bank  = rd_addr_q >> BANK_ADDR;
    rd_en    = (state_q == ST_RUN) && (remain_q != '0) && (!out_valid_q || out_ready);
    end_addr = {2'b00, base_addr} + {1'b0, count};
`ifdef WROM_WRAP_EN
    rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR'(1);
    range_bad = 1'b0;
`else
    rd_addr_d = rd_addr_q + ADDR'(1);
    range_bad = (end_addr > DEPTH_X);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remain_q    <= '0;
      out_addr_q  <= '0;
      bank_sel_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // busy lingers through the done cycle, which also blocks a back-to-back start
          busy_q <= 1'b0;
          if (start && !busy_q) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else if (count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              rd_addr_q <= base_addr;
              remain_q  <= count;
            end
          end
        end
        ST_RUN: begin
          busy_q <= 1'b1;
          if (rd_en) begin
            rd_addr_q   <= rd_addr_d;
            remain_q    <= remain_q - (ADDR+1)'(1);
            out_addr_q  <= rd_addr_q;
            bank_sel_q  <= rd_bank;
            out_valid_q <= 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (remain_q == '0) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      weight_rom_bank #(
        .WIDTH    (WIDTH),
        .NUM      (NUM),
        .BANK_ADDR(BANK_ADDR),
        .DEPTH    (DEPTH),
        .BANK_ID  (gi)
      ) u_bank (
        .clk_i    (clk),
        .rst_i    (rst),
        .rd_en_i  (rd_en && (rd_bank == ADDR'(gi))),
        .rd_addr_i(rd_addr_q[BANK_ADDR-1:0]),
        .rd_data_o(bank_data[gi])
      );
    end
  endgenerate

  // Bank select travels with the read so the mux always matches the data register.
  always_comb begin
    for (int l = 0; l < NUM; l++) begin
      rom_out[l] = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (bank_sel_q == ADDR'(b)) begin
          rom_out[l] = bank_data[b][l*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_weight_rom_streamer.sv
// Self-checking bench for weight_rom_streamer: table-driven transfers, hand-written
// timing/reset sequences and randomized transfers against a behavioural model.
`timescale 1ns/1ps
module tb_weight_rom_streamer;

  localparam int WIDTH     = 16;
  localparam int NUM       = 256;
  localparam int ADDR      = 10;
  localparam int DEPTH     = 576;
  localparam int BANK_ADDR = 9;
`ifdef WROM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR-1:0]   base_addr = '0;
  logic [ADDR:0]     count = '0;
  logic              busy, done, err, out_valid;
  logic [WIDTH-1:0]  rom_out [0:NUM-1];
  logic [ADDR-1:0]   out_addr;
  logic              out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  weight_rom_streamer #(
    .WIDTH(WIDTH), .NUM(NUM), .ADDR(ADDR), .DEPTH(DEPTH), .BANK_ADDR(BANK_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .err(err), .rom_out(rom_out), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    string       tag;
    int          base;
    int          cnt;
    int          pct;
    logic [31:0] mask;
    int          poke;
    bit          exp_err;
  } vec_t;

  vec_t vecs[11];

  // Reference weight image: hashed address/lane, folded from 32 bits to a 16-bit lane.
  function automatic logic [WIDTH-1:0] model_lane(input int addr, input int lane);
    int unsigned h;
    if (addr < 0 || addr >= DEPTH) return '0;
    h = (int'(addr) * 32'h9E3779B1) ^ (int'(lane) * 32'h85EBCA77) ^ 32'h5A5A1234;
    h = h ^ (h >> 15);
    h = h ^ (h >> 16);
    return h[WIDTH-1:0];
  endfunction

  function automatic int model_addr(input int base, input int k);
    return WRAP ? (base + k) % DEPTH : base + k;
  endfunction

  function automatic bit model_err(input int base, input int cnt);
    return !WRAP && (base + cnt > DEPTH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input int addr);
    int bl;
    logic [WIDTH-1:0] got, want;
    bl = -1;
    got = '0;
    want = '0;
    for (int l = 0; l < NUM; l++) begin
      if (bl < 0 && rom_out[l] !== model_lane(addr, l)) begin
        bl = l;
        got = rom_out[l];
        want = model_lane(addr, l);
      end
    end
    total++;
    if (bl >= 0) begin
      bad++;
      $display("FAIL %s: word %0d lane %0d got %0h want %0h", name, addr, bl, got, want);
    end
  endtask

  task automatic chk_zero(input string name);
    int nz;
    nz = 0;
    for (int l = 0; l < NUM; l++) if (rom_out[l] !== '0) nz++;
    chk(name, nz, 0);
  endtask

  // Runs one start request; ready follows pct% random, forced low on mask bits.
  // poke >= 0 re-pulses start (with other operands) in that cycle, which must be ignored.
  task automatic run_xfer(input string tag, input int base, input int cnt, input int pct,
                          input logic [31:0] mask, input int poke, input bit exp_err);
    bit acc;
    int k, last_x, done_cyc, err_cyc, budget;
    acc = !exp_err && (cnt > 0);
    base_addr = ADDR'(base);
    count = (ADDR+1)'(cnt);
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    last_x = -1;
    done_cyc = -1;
    err_cyc = -1;
    budget = cnt * 10 + 20;
    for (int cyc = 0; cyc < budget && done_cyc < 0 && err_cyc < 0; cyc++) begin
      out_ready = (cyc < 32 && mask[cyc]) ? 1'b0 : ($urandom_range(99) < pct);
      start = (cyc == poke);
      if (cyc == poke) begin
        base_addr = ADDR'(200);
        count = (ADDR+1)'(3);
      end
      chk($sformatf("%s busy c%0d", tag, cyc), busy, acc);
      if (err) err_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("%s valid_at_done", tag), out_valid, 0);
      end
      if (out_valid) begin
        chk($sformatf("%s in_range c%0d", tag, cyc), k < cnt, 1);
        if (k < cnt) begin
          chk($sformatf("%s addr k%0d c%0d", tag, k, cyc), out_addr, model_addr(base, k));
          chk_word($sformatf("%s data k%0d c%0d", tag, k, cyc), model_addr(base, k));
        end
        if (out_ready) begin
          last_x = cyc;
          k++;
        end
      end
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("%s err_cycle", tag), err_cyc, exp_err ? 0 : -1);
    chk($sformatf("%s done_cycle", tag), done_cyc, exp_err ? -1 : last_x + 1);
    chk($sformatf("%s words", tag), k, acc ? cnt : 0);
    chk($sformatf("%s busy_after", tag), busy, 0);
    chk($sformatf("%s done_once", tag), done, 0);
    chk($sformatf("%s err_once", tag), err, 0);
    $display("xfer %s base=%0d cnt=%0d words=%0d done_cyc=%0d err_cyc=%0d",
             tag, base, cnt, k, done_cyc, err_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"b0c4",      0,   4, 100, 32'h0,  -1, 1'b0};
    vecs[1]  = '{"bank_edge", 510, 4, 100, 32'h0,  -1, 1'b0};
    vecs[2]  = '{"stall3",    100, 6, 100, 32'h1C, -1, 1'b0};
    vecs[3]  = '{"over_end",  570, 10, 100, 32'h0, -1, !WRAP};
    vecs[4]  = '{"cnt0",      0,   0, 100, 32'h0,  -1, 1'b0};
    vecs[5]  = '{"last_word", 575, 1, 100, 32'h0,  -1, 1'b0};
    vecs[6]  = '{"fits_end",  566, 10, 80, 32'h0,  -1, 1'b0};
    vecs[7]  = '{"one_past",  567, 10, 100, 32'h0, -1, !WRAP};
    vecs[8]  = '{"busy_poke", 0,   5, 100, 32'h0,   2, 1'b0};
    vecs[9]  = '{"poke_done", 20,  2, 100, 32'h0,   3, 1'b0};
    vecs[10] = '{"rand_rdy",  300, 20, 50, 32'h0,  -1, 1'b0};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst valid", out_valid, 0);
    chk("rst addr", out_addr, 0);
    chk_zero("rst lanes");
    rst = 1'b0;
    step();

    // Exact latency: valid from cycle 2 for 4 cycles, done after the 4th transfer
    base_addr = '0;
    count = (ADDR+1)'(4);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lat c1 valid", out_valid, 0);
    chk("lat c1 busy", busy, 1);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("lat c%0d valid", c), out_valid, 1);
      chk($sformatf("lat c%0d addr", c), out_addr, c - 2);
      chk_word($sformatf("lat c%0d data", c), c - 2);
    end
    step();
    chk("lat c6 done", done, 1);
    chk("lat c6 valid", out_valid, 0);
    chk("lat c6 busy", busy, 1);
    step();
    chk("lat c7 done", done, 0);
    chk("lat c7 busy", busy, 0);
    $display("xfer latency_seq base=0 cnt=4");

    for (int i = 0; i < 11; i++) begin
      run_xfer(vecs[i].tag, vecs[i].base, vecs[i].cnt, vecs[i].pct,
               vecs[i].mask, vecs[i].poke, vecs[i].exp_err);
      step();
    end

    // Reset during the third word cycle aborts the transfer with no done
    base_addr = '0;
    count = (ADDR+1)'(8);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort c4 addr", out_addr, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort valid", out_valid, 0);
    chk("abort addr", out_addr, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort err", err, 0);
    chk_zero("abort lanes");
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("abort quiet done c%0d", c), done, 0);
      chk($sformatf("abort quiet valid c%0d", c), out_valid, 0);
    end
    $display("xfer reset_abort base=0 cnt=8");
    run_xfer("after_rst", 40, 5, 100, 32'h0, -1, 1'b0);
    step();

    // Randomized transfers against the model
    for (int i = 0; i < 16; i++) begin
      int b, n, p, pk;
      b = int'($urandom_range(DEPTH - 1));
      n = int'($urandom_range(24));
      p = int'($urandom_range(100, 40));
      pk = ($urandom_range(3) == 0) ? int'($urandom_range(10, 1)) : -1;
      run_xfer($sformatf("rnd%0d", i), b, n, p, 32'h0, pk, model_err(b, n));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
